// File: rtl/gth_refclk_monitor.sv
// Per-channel reference-clock frequency monitor: counts synchronized toggle edges over a shared
// gate window, qualifies each channel's count against a tolerance band and debounces the result.
module gth_refclk_monitor #(
    parameter int NCH         = 16,
    parameter int CNT_W       = 20,
    parameter int GATE_CYCLES = 125000,
    parameter int EXP_CNT     = 10000,
    parameter int TOL         = 50,
    parameter int GOOD_WIN    = 3,
    localparam int SEL_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk_125,
    input  logic             rst,
    input  logic [NCH-1:0]   refclk_tgl,
    input  logic [SEL_W-1:0] sel,
    output logic [CNT_W-1:0] sel_count,
    output logic [NCH-1:0]   ok,
    output logic [NCH-1:0]   absent,
    output logic             all_ok,
    output logic             window_done
);

    localparam int GATE_W   = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int STREAK_W = $clog2(GOOD_WIN + 1);
    localparam logic [GATE_W-1:0]   GATE_LAST  = GATE_W'(GATE_CYCLES - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(GOOD_WIN);
    localparam logic [CNT_W-1:0]    CNT_MAX    = '1;
    // Bounds are kept in 64 bits so a tolerance larger than the expectation clamps at zero.
    localparam logic [63:0] LO_BOUND = (EXP_CNT > TOL) ? 64'(EXP_CNT - TOL) : 64'd0;
    localparam logic [63:0] HI_BOUND = 64'(EXP_CNT) + 64'(TOL);

    logic [NCH-1:0]      sync1_q, sync2_q, hist_q;
    logic [NCH-1:0]      edgeDet;
    logic [GATE_W-1:0]   gate_q;
    logic                terminal;
    logic [CNT_W-1:0]    cnt_q    [NCH];
    logic [CNT_W-1:0]    cnt_d    [NCH];
    logic [CNT_W-1:0]    latch_q  [NCH];
    logic [STREAK_W-1:0] streak_q [NCH];
    logic [STREAK_W-1:0] streak_d [NCH];
    logic [NCH-1:0]      good;
    logic [NCH-1:0]      ok_d;
    logic [NCH-1:0]      ok_q, absent_q;
    logic                allOk_q, windowDone_q;
    logic [CNT_W-1:0]    selCount_q, selCount_d;

    assign edgeDet  = sync2_q ^ hist_q;
    assign terminal = (gate_q == GATE_LAST);

    // cnt_d already includes an edge seen in the terminal cycle, so it is also the value to latch.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (edgeDet[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            good[i] = (64'(cnt_d[i]) >= LO_BOUND) && (64'(cnt_d[i]) <= HI_BOUND);
            if (!good[i]) begin
                streak_d[i] = '0;
            end else if (streak_q[i] == STREAK_MAX) begin
                streak_d[i] = STREAK_MAX;
            end else begin
                streak_d[i] = streak_q[i] + STREAK_W'(1);
            end
            ok_d[i] = (streak_d[i] == STREAK_MAX);
        end
    end

    always_comb begin
        selCount_d = '0;
        if (32'(sel) < NCH) begin
            selCount_d = latch_q[sel];
        end
    end

    always_ff @(posedge clk_125 or posedge rst) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            hist_q       <= '0;
            gate_q       <= '0;
            ok_q         <= '0;
            absent_q     <= '0;
            allOk_q      <= 1'b0;
            windowDone_q <= 1'b0;
            selCount_q   <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]    <= '0;
                latch_q[i]  <= '0;
                streak_q[i] <= '0;
            end
        end else begin
            sync1_q      <= refclk_tgl;
            sync2_q      <= sync1_q;
            hist_q       <= sync2_q;
            windowDone_q <= terminal;
            selCount_q   <= selCount_d;
            if (terminal) begin
                gate_q  <= '0;
                ok_q    <= ok_d;
                allOk_q <= &ok_d;
                for (int i = 0; i < NCH; i++) begin
                    latch_q[i]  <= cnt_d[i];
                    cnt_q[i]    <= '0;
                    streak_q[i] <= streak_d[i];
                    absent_q[i] <= (cnt_d[i] == '0);
                end
            end else begin
                gate_q <= gate_q + GATE_W'(1);
                for (int i = 0; i < NCH; i++) begin
                    cnt_q[i] <= cnt_d[i];
                end
            end
        end
    end

    assign sel_count   = selCount_q;
    assign ok          = ok_q;
    assign absent      = absent_q;
    assign all_ok      = allOk_q;
    assign window_done = windowDone_q;

endmodule

// File: tb/tb_gth_refclk_monitor.sv
// Directed bench for gth_refclk_monitor: a 100-cycle window with two instances (8-bit and 5-bit counters)
// sharing clock, reset and toggle inputs.
module tb_gth_refclk_monitor;

    localparam int NCH = 4;

    logic           clk_125 = 1'b0;
    logic           rst;
    logic [NCH-1:0] tgl;
    logic [1:0]     sel;
    logic [7:0]     selCount;
    logic [4:0]     selCount2;
    logic [NCH-1:0] ok, absent, ok2, absent2;
    logic           allOk, windowDone, allOk2, windowDone2;

    int checkCount = 0;
    int passCount  = 0;

    // Toggle generator state: per-channel period (0 = held), plus the window carrying the short
    // (period 5 -> 20 edges) burst on ch1 and the window from which ch0/ch2/ch3 switch to period 4.
    int per [NCH];
    int badWin    = 5;
    int switchWin = 7;
    int phase     = 0;

    gth_refclk_monitor #(
        .NCH(NCH), .CNT_W(8), .GATE_CYCLES(100), .EXP_CNT(25), .TOL(2), .GOOD_WIN(3)
    ) dut (
        .clk_125(clk_125), .rst(rst), .refclk_tgl(tgl), .sel(sel),
        .sel_count(selCount), .ok(ok), .absent(absent), .all_ok(allOk), .window_done(windowDone)
    );

    gth_refclk_monitor #(
        .NCH(NCH), .CNT_W(5), .GATE_CYCLES(100), .EXP_CNT(25), .TOL(2), .GOOD_WIN(3)
    ) dutSat (
        .clk_125(clk_125), .rst(rst), .refclk_tgl(tgl), .sel(sel),
        .sel_count(selCount2), .ok(ok2), .absent(absent2), .all_ok(allOk2), .window_done(windowDone2)
    );

    always #5 clk_125 = ~clk_125;

    // tph = phase + 2 aligns toggle indices with the windows that count them (3-cycle detect latency),
    // so window w sees exactly the toggles with tph in [100(w-1), 100w-1].
    initial begin
        int tph, win, p;
        tgl = '0;
        forever begin
            @(posedge clk_125);
            #1;
            if (rst) begin
                phase = 0;
            end else begin
                phase++;
                tph = phase + 2;
                win = tph / 100 + 1;
                for (int ch = 0; ch < NCH; ch++) begin
                    p = per[ch];
                    if (ch == 1 && win == badWin) p = 5;
                    if (ch != 1 && win >= switchWin) p = 4;
                    if (p != 0 && (tph % p) == 0) tgl[ch] = ~tgl[ch];
                end
            end
        end
    end

    task automatic waitDone(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk_125);
            n++;
        end while (windowDone !== 1'b1 && n < 150);
        checkCount++;
        if (windowDone !== 1'b1) $display("[TB] FAIL %s_timeout: window_done=%b after %0d cycles, required 1", tag, windowDone, n);
        else passCount++;
    endtask

    task automatic readCount(input logic [1:0] ch);
        sel = ch;
        @(negedge clk_125);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        sel = 2'd0;
        per[0] = 2; per[1] = 4; per[2] = 0; per[3] = 1;
        repeat (3) @(posedge clk_125);
        @(negedge clk_125);
        checkCount++;
        if ({ok, absent, allOk, windowDone, selCount} !== 19'd0)
            $display("[TB] FAIL reset_outputs: ok=%b absent=%b all_ok=%b wd=%b sel_count=%0d, required all 0", ok, absent, allOk, windowDone, selCount);
        else passCount++;
        checkCount++;
        if ({ok2, absent2, allOk2, windowDone2, selCount2} !== 15'd0)
            $display("[TB] FAIL reset_outputs_sat: ok=%b absent=%b all_ok=%b wd=%b sel_count=%0d, required all 0", ok2, absent2, allOk2, windowDone2, selCount2);
        else passCount++;
        @(posedge clk_125);
        #2 rst = 1'b0;
    endtask

    task automatic test_first_window;
        waitDone("done1");
        checkCount++;
        if (absent !== 4'b0100) $display("[TB] FAIL absent_w1: absent=%b required 0100", absent); else passCount++;
        checkCount++;
        if (ok !== 4'b0000) $display("[TB] FAIL ok_w1: ok=%b required 0000", ok); else passCount++;
        checkCount++;
        if (allOk !== 1'b0) $display("[TB] FAIL all_ok_w1: all_ok=%b required 0", allOk); else passCount++;
        @(negedge clk_125);
        checkCount++;
        if (windowDone !== 1'b0) $display("[TB] FAIL done_pulse_width: window_done=%b required 0", windowDone); else passCount++;
        readCount(2'd2);
        checkCount++;
        if (selCount !== 8'd0) $display("[TB] FAIL sel_count_ch2: sel_count=%0d required 0", selCount); else passCount++;
    endtask

    task automatic test_steady_counts;
        waitDone("done2");
        checkCount++;
        if (ok !== 4'b0000) $display("[TB] FAIL ok_w2: ok=%b required 0000", ok); else passCount++;
        readCount(2'd0);
        checkCount++;
        if (selCount !== 8'd50) $display("[TB] FAIL count_ch0: sel_count=%0d required 50", selCount); else passCount++;
        checkCount++;
        if (selCount2 !== 5'd31) $display("[TB] FAIL sat_count_ch0: sel_count=%0d required 31", selCount2); else passCount++;
        readCount(2'd1);
        checkCount++;
        if (selCount !== 8'd25) $display("[TB] FAIL count_ch1: sel_count=%0d required 25", selCount); else passCount++;
        readCount(2'd3);
        checkCount++;
        if (selCount !== 8'd100) $display("[TB] FAIL count_ch3: sel_count=%0d required 100", selCount); else passCount++;
        checkCount++;
        if (selCount2 !== 5'd31) $display("[TB] FAIL sat_count_ch3: sel_count=%0d required 31", selCount2); else passCount++;
        checkCount++;
        if (ok2[3] !== 1'b0) $display("[TB] FAIL sat_ok_ch3: ok[3]=%b required 0", ok2[3]); else passCount++;
    endtask

    task automatic test_ok_rise;
        waitDone("done3");
        checkCount++;
        if (ok !== 4'b0010) $display("[TB] FAIL ok_w3: ok=%b required 0010", ok); else passCount++;
        checkCount++;
        if (allOk !== 1'b0) $display("[TB] FAIL all_ok_w3: all_ok=%b required 0", allOk); else passCount++;
        waitDone("done4");
        checkCount++;
        if (ok !== 4'b0010) $display("[TB] FAIL ok_w4: ok=%b required 0010", ok); else passCount++;
    endtask

    task automatic test_bad_window;
        waitDone("done5");
        checkCount++;
        if (ok !== 4'b0000) $display("[TB] FAIL ok_bad_w5: ok=%b required 0000", ok); else passCount++;
        readCount(2'd1);
        checkCount++;
        if (selCount !== 8'd20) $display("[TB] FAIL count_bad_ch1: sel_count=%0d required 20", selCount); else passCount++;
        waitDone("done6");
        checkCount++;
        if (ok !== 4'b0000) $display("[TB] FAIL ok_w6: ok=%b required 0000", ok); else passCount++;
        waitDone("done7");
        checkCount++;
        if (ok !== 4'b0000) $display("[TB] FAIL ok_w7: ok=%b required 0000", ok); else passCount++;
        checkCount++;
        if (absent !== 4'b0000) $display("[TB] FAIL absent_w7: absent=%b required 0000", absent); else passCount++;
        waitDone("done8");
        checkCount++;
        if (ok !== 4'b0010) $display("[TB] FAIL ok_w8: ok=%b required 0010", ok); else passCount++;
        checkCount++;
        if (allOk !== 1'b0) $display("[TB] FAIL all_ok_w8: all_ok=%b required 0", allOk); else passCount++;
    endtask

    task automatic test_all_ok;
        waitDone("done9");
        checkCount++;
        if (ok !== 4'b1111) $display("[TB] FAIL ok_w9: ok=%b required 1111", ok); else passCount++;
        checkCount++;
        if (allOk !== 1'b1) $display("[TB] FAIL all_ok_w9: all_ok=%b required 1", allOk); else passCount++;
        checkCount++;
        if ({ok2, allOk2} !== 5'b11111) $display("[TB] FAIL sat_all_ok_w9: ok=%b all_ok=%b required 1111/1", ok2, allOk2); else passCount++;
    endtask

    task automatic test_reset_mid;
        int n;
        waitDone("done10");
        repeat (50) @(posedge clk_125);
        #2 rst = 1'b1;
        #1;
        checkCount++;
        if ({ok, absent, allOk, windowDone, selCount} !== 19'd0)
            $display("[TB] FAIL mid_reset_outputs: ok=%b absent=%b all_ok=%b wd=%b sel_count=%0d, required all 0", ok, absent, allOk, windowDone, selCount);
        else passCount++;
        repeat (3) @(posedge clk_125);
        #2 rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk_125);
            n++;
        end while (windowDone !== 1'b1 && n < 200);
        checkCount++;
        if (n !== 101) $display("[TB] FAIL restart_window_len: window_done in cycle %0d after release, required 101", n);
        else passCount++;
    endtask

    initial begin
        test_reset();
        test_first_window();
        test_steady_counts();
        test_ok_rise();
        test_bad_window();
        test_all_ok();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/gth_refclk_monitor.md
GTH_REFCLK_MONITOR -- requirements
Module: gth_refclk_monitor

Interface
REQ-001 Parameter NCH, default 16: number of monitored GTH reference-clock channels.
REQ-002 Parameter CNT_W, default 20: width of the per-channel edge counters and of the latched counts.
REQ-003 Parameter GATE_CYCLES, default 125000: measurement window length in clk_125 cycles (1 ms).
REQ-004 Parameter EXP_CNT, default 10000: expected edge count per window for a healthy reference clock.
REQ-005 Parameter TOL, default 50: allowed absolute deviation from EXP_CNT.
REQ-006 Parameter GOOD_WIN, default 3: number of consecutive good windows required before ok asserts.
REQ-007 Port clk_125, input, 1: the single block clock (free-running fabric clock).
REQ-008 Port rst, input, 1: reset, asynchronous, active-high.
REQ-009 Port refclk_tgl, input, NCH: per-channel toggle signals, each toggling once per divided refclk period; asynchronous to clk_125.
REQ-010 Port sel, input, max(1,$clog2(NCH)): channel select for count readback.
REQ-011 Port sel_count, output, CNT_W: last latched edge count of channel sel, registered.
REQ-012 Port ok, output, NCH: per-channel frequency-valid flags.
REQ-013 Port absent, output, NCH: per-channel flags, set when the last window counted zero edges.
REQ-014 Port all_ok, output, 1: AND of ok.
REQ-015 Port window_done, output, 1: one-cycle pulse at the end of each window.

Function
REQ-016 Each refclk_tgl bit SHALL pass through a 2-flop synchronizer followed by one history flop; an edge is any difference between the synchronized bit and its history flop (both polarities count).
REQ-017 A toggle change on the input SHALL be counted no later than 3 clk_125 cycles after it is sampled.
REQ-018 The gate counter SHALL run 0..GATE_CYCLES-1 and wrap to 0; the cycle with gate=GATE_CYCLES-1 is the terminal cycle.
REQ-019 In the cycle after the terminal cycle, window_done SHALL be 1 for exactly one cycle; latched counts, ok, absent and all_ok SHALL update in that same cycle.
REQ-020 At the terminal cycle, each edge counter SHALL latch its value (including any edge detected in the terminal cycle) and reload to 0.
REQ-021 Edge counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 A window is good iff EXP_CNT-TOL <= count <= EXP_CNT+TOL, computed without unsigned underflow (a lower bound below 0 is treated as 0).
REQ-023 Per channel, the good-streak counter SHALL increment on a good window, saturating at GOOD_WIN, and clear to 0 on a bad window.
REQ-024 ok[i] SHALL be 1 iff the streak equals GOOD_WIN after the update; one bad window SHALL clear ok[i] immediately.
REQ-025 absent[i] SHALL be 1 iff the latched count equals 0.
REQ-026 sel_count SHALL be the registered latched count of channel sel, valid 1 cycle after sel changes; sel >= NCH SHALL return 0.
REQ-027 All channels SHALL share one gate counter; no channel state depends on another channel.

Reset
REQ-028 While rst=1: gate counter, edge counters, latched counts, streaks and synchronizer flops SHALL be 0; ok=0, absent=0, all_ok=0, window_done=0, sel_count=0.
REQ-029 Deasserting rst SHALL start a full window at gate=0; asserting rst mid-window SHALL discard the partial counts with no window_done pulse.

Verification
(Bench overrides: NCH=4, GATE_CYCLES=100, EXP_CNT=25, TOL=2, GOOD_WIN=3, CNT_W=8.)
REQ-030 Toggle ch0 every 2 cycles (50 edges per window) -> latched count 50; ok[0]=0 always; absent[0]=0.
REQ-031 Toggle ch1 every 4 cycles (25 edges per window) -> ok[1] rises in the window_done cycle of the 3rd window; all_ok follows only when all channels are good.
REQ-032 ch2 held constant -> absent[2]=1 and ok[2]=0 at the first window_done; sel=2 gives sel_count=0 one cycle later.
REQ-033 ch1 healthy with ok[1]=1, then one window with 20 edges -> ok[1]=0 at that window_done; 3 more good windows are needed before ok[1]=1 again.
REQ-034 Toggle ch3 every cycle with CNT_W=5 -> count saturates at 31 with no wrap; window bad; ok[3]=0.
REQ-035 Pulse rst at gate=50 -> all outputs 0 immediately; the next window_done occurs exactly 101 cycles after rst deasserts.
